multicycle_processor_core: RTL
==============================

// Module: multicycle_processor_core
// PURPOSE
//  Parametrised multi-cycle successor of the single-cycle 8-bit core. Runs a FETCH/DECODE/EXEC/MEM FSM.
//  Instruction and data memories are external and use req/ack handshakes, so wait-state memories can be attached.
//  Adds Z/C flags, HALT and optional branching. Sits at the top of the processor hierarchy.
// PARAMETERS
//  DATA_W   8  register/ALU/data-memory address and data width
//  REG_AW   3  register index width; NUM_REGS = 2**REG_AW
//  PC_W     8  program counter / instruction address width
//  INSTR_W  = 4+2*REG_AW (derived, localparam); format {opcode[3:0], dest, src}
// PORTS
//  clk          in   1        rising-edge clock
//  reset        in   1        asynchronous, active-low reset
//  imem_req     out  1        instruction fetch request
//  imem_addr    out  PC_W     fetch address (= pc)
//  imem_ack     in   1        fetch data valid this cycle
//  imem_rdata   in   INSTR_W  fetched instruction
//  dmem_req     out  1        data access request
//  dmem_we      out  1        1 = store, 0 = load
//  dmem_addr    out  DATA_W   R[src]
//  dmem_wdata   out  DATA_W   R[dest]
//  dmem_ack     in   1        access complete; rdata valid for loads
//  dmem_rdata   in   DATA_W   load data
//  pc           out  PC_W     current program counter
//  flag_z       out  1        zero flag
//  flag_c       out  1        carry/borrow flag
//  halted       out  1        core stopped by HALT
// BEHAVIOUR
//  Reset (reset=0, async): pc, all registers, flags, halted, every req/we/addr/wdata output = 0; state=FETCH.
//  Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 NOT (d=~s), 7 MOV (d=s), 8 LD d=mem[R[s]],
//   9 ST mem[R[s]]=R[d], A JMP, B BRZ, C BRC (target R[s] truncated to PC_W), D INC d=d+1, E reserved=NOP, F HALT.
//  FSM: FETCH: imem_req=1, imem_addr=pc; on imem_ack capture IR, go to DECODE.
//   DECODE: read R[dest], R[src] into operand latches; go to EXEC.
//   EXEC: ALU ops write dest and flags, pc+=1, go to FETCH. LD/ST go to MEM.
//   EXEC, jump/branch: pc=target if taken, else pc+1.
//   EXEC, HALT: halted=1, go to HALT.
//   MEM: dmem_req=1, dmem_we=(ST); on dmem_ack: LD writes dest=dmem_rdata, pc+=1, go to FETCH.
//   HALT: terminal; no requests issued; exit only via reset.
//  Handshake: req rises with address/wdata stable and held until ack sampled high.
//   req deasserts the cycle after ack. Ack in the same cycle req first rises is legal (zero-wait).
//   Ack while req=0 is ignored.
//  Latency, zero-wait memories: ALU/jump/NOP = 3 cycles per instr; LD/ST = 4. Each memory wait cycle adds 1.
//  Arithmetic: results mod 2**DATA_W.
//   ADD/INC: C = carry-out. SUB: C = borrow (R[d] < R[s]). Logic/NOT: C = 0.
//   Z = (result == 0) for opcodes 1-6 and D. MOV/LD/NOP/jumps leave flags unchanged.
//  pc wraps 2**PC_W-1 -> 0 silently. dest==src is legal: operands latched in DECODE.
//  Reset mid-handshake: req drops immediately (async); no partial register write occurs.
// CONFIGURATION
//  PROC_BRANCH_EN defined: JMP/BRZ/BRC as above (BRZ taken if flag_z, BRC if flag_c).
//  PROC_BRANCH_EN undefined: opcodes A-C execute as NOP (pc+1, flags kept); no branch logic synthesised.
// TESTING
//  1 Hold reset=0 5 cycles, then release -> all outputs 0; next edge imem_req=1, imem_addr=0.
//  2 LD R1=200, LD R2=100, ADD R1,R2 -> R1=44, flag_c=1, flag_z=0; ADD retires in 3 cycles.
//  3 SUB R1,R1 -> R1=0, Z=1, C=0.
//  4 ST, dmem_ack delayed 3 cycles -> dmem_req/addr/wdata/we=1 stable 4 cycles; req low the cycle after ack.
//  5 PROC_BRANCH_EN: Z=1, BRZ R3 (R3=0x40) -> pc=0x40.
//    Z=0 -> pc+1. Macro off -> pc+1 always.
//  6 NOP at pc=255 -> pc=0. HALT -> halted=1, imem_req stays 0 for 20 cycles.
//    Reset asserted while dmem_req=1 -> dmem_req=0 same cycle.

Source files
------------

// File: rtl/multicycle_processor_core.sv
// multicycle_processor_core: FETCH/DECODE/EXEC/MEM core with req/ack instruction and data memories.
// Define PROC_BRANCH_EN to enable JMP/BRZ/BRC; without it opcodes A-C retire as NOP.
module multicycle_processor_core #(
    parameter int DATA_W = 8,
    parameter int REG_AW = 3,
    parameter int PC_W   = 8
) (
    input  logic                clk,
    input  logic                reset,
    output logic                imem_req,
    output logic [PC_W-1:0]     imem_addr,
    input  logic                imem_ack,
    input  logic [3+2*REG_AW:0] imem_rdata,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [DATA_W-1:0]   dmem_addr,
    output logic [DATA_W-1:0]   dmem_wdata,
    input  logic                dmem_ack,
    input  logic [DATA_W-1:0]   dmem_rdata,
    output logic [PC_W-1:0]     pc,
    output logic                flag_z,
    output logic                flag_c,
    output logic                halted
);
    localparam int INSTR_W  = 4 + 2*REG_AW;
    localparam int NUM_REGS = 2**REG_AW;
    localparam logic [3:0] OP_ADD = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3, OP_OR  = 4'h4,
                           OP_XOR = 4'h5, OP_NOT = 4'h6, OP_MOV = 4'h7, OP_LD  = 4'h8,
                           OP_ST  = 4'h9, OP_JMP = 4'hA, OP_BRZ = 4'hB, OP_BRC = 4'hC,
                           OP_INC = 4'hD, OP_HALT = 4'hF;
    localparam logic [DATA_W:0] ALU_ONE = 1;
    localparam logic [PC_W-1:0] PC_ONE  = 1;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALT} state_t;

    state_t              r_state;
    logic [INSTR_W-1:0]  r_ir;
    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [DATA_W-1:0]   r_opa, r_opb;
    logic [PC_W-1:0]     r_pc;
    logic                r_z, r_c, r_halted;
    logic                r_imem_req, r_dmem_req, r_dmem_we;
    logic [DATA_W-1:0]   r_dmem_addr, r_dmem_wdata;

    logic [3:0]          w_op;
    logic [REG_AW-1:0]   w_d, w_s;
    logic [DATA_W:0]     w_alu;
    logic                w_setf, w_wr;
    logic [PC_W-1:0]     w_next_pc;

    assign w_op   = r_ir[INSTR_W-1 -: 4];
    assign w_d    = r_ir[2*REG_AW-1 -: REG_AW];
    assign w_s    = r_ir[REG_AW-1:0];
    assign w_setf = (w_op >= OP_ADD && w_op <= OP_NOT) || w_op == OP_INC;
    assign w_wr   = w_setf || w_op == OP_MOV;

    // Top bit of w_alu is carry for ADD/INC and borrow for SUB; logic ops leave it 0.
    always_comb begin
        w_alu = '0;
        case (w_op)
            OP_ADD:  w_alu = {1'b0, r_opa} + {1'b0, r_opb};
            OP_SUB:  w_alu = {1'b0, r_opa} - {1'b0, r_opb};
            OP_AND:  w_alu = {1'b0, r_opa & r_opb};
            OP_OR:   w_alu = {1'b0, r_opa | r_opb};
            OP_XOR:  w_alu = {1'b0, r_opa ^ r_opb};
            OP_NOT:  w_alu = {1'b0, ~r_opb};
            OP_MOV:  w_alu = {1'b0, r_opb};
            OP_INC:  w_alu = {1'b0, r_opa} + ALU_ONE;
            default: w_alu = '0;
        endcase
    end

`ifdef PROC_BRANCH_EN
    logic w_taken;
    assign w_taken   = w_op == OP_JMP || (w_op == OP_BRZ && r_z) || (w_op == OP_BRC && r_c);
    assign w_next_pc = w_taken ? PC_W'(r_opb) : r_pc + PC_ONE;
`else
    assign w_next_pc = r_pc + PC_ONE;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_FETCH;
            r_ir         <= '0;
            r_opa        <= '0;
            r_opb        <= '0;
            r_pc         <= '0;
            r_z          <= 1'b0;
            r_c          <= 1'b0;
            r_halted     <= 1'b0;
            r_imem_req   <= 1'b0;
            r_dmem_req   <= 1'b0;
            r_dmem_we    <= 1'b0;
            r_dmem_addr  <= '0;
            r_dmem_wdata <= '0;
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (r_imem_req && imem_ack) begin
                        r_ir       <= imem_rdata;
                        r_imem_req <= 1'b0;
                        r_state    <= S_DECODE;
                    end else begin
                        r_imem_req <= 1'b1;
                    end
                end
                S_DECODE: begin
                    r_opa   <= r_regs[w_d];
                    r_opb   <= r_regs[w_s];
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    if (w_op == OP_HALT) begin
                        r_halted <= 1'b1;
                        r_state  <= S_HALT;
                    end else if (w_op == OP_LD || w_op == OP_ST) begin
                        r_dmem_req   <= 1'b1;
                        r_dmem_we    <= w_op == OP_ST;
                        r_dmem_addr  <= r_opb;
                        r_dmem_wdata <= r_opa;
                        r_state      <= S_MEM;
                    end else begin
                        if (w_wr) r_regs[w_d] <= w_alu[DATA_W-1:0];
                        if (w_setf) begin
                            r_z <= w_alu[DATA_W-1:0] == '0;
                            r_c <= w_alu[DATA_W];
                        end
                        r_pc       <= w_next_pc;
                        r_imem_req <= 1'b1;
                        r_state    <= S_FETCH;
                    end
                end
                S_MEM: begin
                    if (r_dmem_req && dmem_ack) begin
                        if (!r_dmem_we) r_regs[w_d] <= dmem_rdata;
                        r_dmem_req <= 1'b0;
                        r_pc       <= r_pc + PC_ONE;
                        r_imem_req <= 1'b1;
                        r_state    <= S_FETCH;
                    end
                end
                default: r_state <= S_HALT;
            endcase
        end
    end

    assign imem_req   = r_imem_req;
    assign imem_addr  = r_pc;
    assign dmem_req   = r_dmem_req;
    assign dmem_we    = r_dmem_we;
    assign dmem_addr  = r_dmem_addr;
    assign dmem_wdata = r_dmem_wdata;
    assign pc         = r_pc;
    assign flag_z     = r_z;
    assign flag_c     = r_c;
    assign halted     = r_halted;
endmodule
